// File: rtl/l2_intl_pkg.sv
// Shared widths and types for the L2 TCDM interleaver.
// Index widths are functions so each module sizes them from its own parameters.
package l2_intl_pkg;

    localparam int unsigned MST_ID_W = 8;

    typedef logic [MST_ID_W-1:0] mst_id_t;

    function automatic int unsigned bank_idx_w(input int unsigned nb);
        return $clog2(nb);
    endfunction

    function automatic int unsigned mst_idx_w(input int unsigned nm);
        return (nm > 1) ? $clog2(nm) : 1;
    endfunction

endpackage

// File: rtl/xbar_tcdm_bus_36.sv
// TCDM request/response bus with a 36-bit data path (32 data + 4 tag bits).
// Master drives the request, Slave drives grant and response.
interface XBAR_TCDM_BUS_36;

    logic        req;
    logic [31:0] add;
    logic        wen;
    logic [3:0]  be;
    logic [35:0] wdata;
    logic        gnt;
    logic        r_valid;
    logic [35:0] r_rdata;
    logic        r_opc;

    modport Master (
        output req, add, wen, be, wdata,
        input  gnt, r_valid, r_rdata, r_opc
    );

    modport Slave (
        input  req, add, wen, be, wdata,
        output gnt, r_valid, r_rdata, r_opc
    );

endinterface

// File: rtl/l2_bank_arb.sv
// Per-bank arbiter: one-hot grant and winner index from a request vector.
// L2_INTL_RR_ARB_EN selects round-robin; otherwise lowest index wins.
module l2_bank_arb
    import l2_intl_pkg::*;
#(
    parameter int unsigned NB_MASTERS = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [NB_MASTERS-1:0] req,
    output logic [NB_MASTERS-1:0] gnt_oh,
    output mst_id_t               winner
);

    localparam int unsigned PTR_W = mst_idx_w(NB_MASTERS);

    typedef logic [PTR_W-1:0] ptr_t;

    ptr_t ptr;

`ifdef L2_INTL_RR_ARB_EN
    ptr_t ptr_q;

    assign ptr = ptr_q;

    // Pointer moves one past the winner whenever anything was granted
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else if (|req) begin
            if (int'(winner) + 1 >= int'(NB_MASTERS)) begin
                ptr_q <= '0;
            end else begin
                ptr_q <= ptr_t'(int'(winner) + 1);
            end
        end
    end
`else
    logic unused_clk;

    assign ptr        = '0;
    assign unused_clk = clk_i ^ rst_ni;
`endif

    // Search starts at the pointer and wraps; first requester wins
    always_comb begin
        int   k;
        logic found;
        gnt_oh = '0;
        winner = '0;
        found  = 1'b0;
        k      = 0;
        for (int i = 0; i < int'(NB_MASTERS); i++) begin
            k = int'(ptr) + i;
            if (k >= int'(NB_MASTERS)) begin
                k = k - int'(NB_MASTERS);
            end
            if (!found && req[k]) begin
                found     = 1'b1;
                gnt_oh[k] = 1'b1;
                winner    = mst_id_t'(k);
            end
        end
    end

endmodule

// File: rtl/l2_tcdm_interleaver.sv
// Routes TCDM masters onto word-interleaved single-cycle L2 banks.
// Arbiter mode chosen by L2_INTL_RR_ARB_EN (round-robin) or fixed priority.
module l2_tcdm_interleaver
    import l2_intl_pkg::*;
#(
    parameter int unsigned NB_MASTERS = 4,
    parameter int unsigned NB_BANKS   = 4
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    XBAR_TCDM_BUS_36.Slave  master_slave [NB_MASTERS],
    XBAR_TCDM_BUS_36.Master bank_master  [NB_BANKS]
);

    localparam int unsigned BANK_IDX_W = bank_idx_w(NB_BANKS);

    typedef logic [BANK_IDX_W-1:0] bidx_t;

    logic [NB_MASTERS-1:0] m_req;
    logic [31:0]           m_add   [NB_MASTERS];
    logic [NB_MASTERS-1:0] m_wen;
    logic [3:0]            m_be    [NB_MASTERS];
    logic [35:0]           m_wdata [NB_MASTERS];
    bidx_t                 m_bidx  [NB_MASTERS];
    logic [NB_MASTERS-1:0] m_gnt;
    logic [NB_MASTERS-1:0] m_rvalid;
    logic [35:0]           m_rdata [NB_MASTERS];

    logic [NB_BANKS-1:0]   b_req;
    logic [31:0]           b_add   [NB_BANKS];
    logic [NB_BANKS-1:0]   b_wen;
    logic [3:0]            b_be    [NB_BANKS];
    logic [35:0]           b_wdata [NB_BANKS];
    logic [NB_BANKS-1:0]   b_gnt;
    logic [35:0]           b_rdata [NB_BANKS];
    logic [NB_BANKS-1:0]   unused_bank;

    logic [NB_MASTERS-1:0] arb_req [NB_BANKS];
    logic [NB_MASTERS-1:0] arb_gnt [NB_BANKS];
    mst_id_t               arb_win [NB_BANKS];

    logic [NB_BANKS-1:0]   resp_vld_q;
    mst_id_t               resp_id_q [NB_BANKS];

    for (genvar m = 0; m < NB_MASTERS; m++) begin : g_mst
        assign m_req[m]   = master_slave[m].req;
        assign m_add[m]   = master_slave[m].add;
        assign m_wen[m]   = master_slave[m].wen;
        assign m_be[m]    = master_slave[m].be;
        assign m_wdata[m] = master_slave[m].wdata;
        assign m_bidx[m]  = m_add[m][2+BANK_IDX_W-1:2];

        assign master_slave[m].gnt     = m_gnt[m];
        assign master_slave[m].r_valid = m_rvalid[m];
        assign master_slave[m].r_rdata = m_rdata[m];
        assign master_slave[m].r_opc   = 1'b0;
    end

    for (genvar b = 0; b < NB_BANKS; b++) begin : g_bank
        assign bank_master[b].req   = b_req[b];
        assign bank_master[b].add   = b_add[b];
        assign bank_master[b].wen   = b_wen[b];
        assign bank_master[b].be    = b_be[b];
        assign bank_master[b].wdata = b_wdata[b];

        assign b_gnt[b]       = bank_master[b].gnt;
        assign b_rdata[b]     = bank_master[b].r_rdata;
        assign unused_bank[b] = bank_master[b].r_valid
                              ^ bank_master[b].r_opc;

        l2_bank_arb #(
            .NB_MASTERS (NB_MASTERS)
        ) i_arb (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .req    (arb_req[b]),
            .gnt_oh (arb_gnt[b]),
            .winner (arb_win[b])
        );
    end

    // Decode each master's target bank into per-bank request vectors
    always_comb begin
        for (int b = 0; b < int'(NB_BANKS); b++) begin
            arb_req[b] = '0;
            for (int m = 0; m < int'(NB_MASTERS); m++) begin
                arb_req[b][m] = m_req[m] && (m_bidx[m] == bidx_t'(b));
            end
        end
    end

    // Forward the winner's request; idle banks see a zeroed read
    always_comb begin
        for (int b = 0; b < int'(NB_BANKS); b++) begin
            b_req[b]   = |arb_req[b];
            b_add[b]   = '0;
            b_wen[b]   = 1'b1;
            b_be[b]    = '0;
            b_wdata[b] = '0;
            for (int m = 0; m < int'(NB_MASTERS); m++) begin
                if (arb_gnt[b][m]) begin
                    b_add[b]   = m_add[m];
                    b_wen[b]   = m_wen[m];
                    b_be[b]    = m_be[m];
                    b_wdata[b] = m_wdata[m];
                end
            end
        end
    end

    // Bank grant flows straight back to that bank's winner
    always_comb begin
        m_gnt = '0;
        for (int b = 0; b < int'(NB_BANKS); b++) begin
            m_gnt = m_gnt | (arb_gnt[b] & {NB_MASTERS{b_gnt[b]}});
        end
    end

    // Remember which master owns next cycle's response on each bank
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            resp_vld_q <= '0;
            for (int b = 0; b < int'(NB_BANKS); b++) begin
                resp_id_q[b] <= '0;
            end
        end else begin
            resp_vld_q <= b_req & b_gnt;
            for (int b = 0; b < int'(NB_BANKS); b++) begin
                resp_id_q[b] <= arb_win[b];
            end
        end
    end

    // Steer each pending bank response to its owner
    always_comb begin
        for (int m = 0; m < int'(NB_MASTERS); m++) begin
            m_rvalid[m] = 1'b0;
            m_rdata[m]  = '0;
            for (int b = 0; b < int'(NB_BANKS); b++) begin
                if (resp_vld_q[b] && resp_id_q[b] == mst_id_t'(m)) begin
                    m_rvalid[m] = 1'b1;
                    m_rdata[m]  = b_rdata[b];
                end
            end
        end
    end

endmodule

// File: tb/tb_l2_tcdm_interleaver.sv
// Directed bench for l2_tcdm_interleaver with single-cycle bank models.
// Round-robin expectations apply when L2_INTL_RR_ARB_EN is defined.
module tb_l2_tcdm_interleaver;

    logic clk_i = 1'b0;
    logic rst_ni;

    always #5 clk_i = ~clk_i;

    XBAR_TCDM_BUS_36 ms [4] ();
    XBAR_TCDM_BUS_36 bk [4] ();

    l2_tcdm_interleaver #(
        .NB_MASTERS (4),
        .NB_BANKS   (4)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .master_slave (ms),
        .bank_master  (bk)
    );

    logic [3:0]  m_req;
    logic [31:0] m_add [4];
    logic [3:0]  m_wen;
    logic [3:0]  m_be  [4];
    logic [35:0] m_wd  [4];
    logic [3:0]  m_gnt;
    logic [3:0]  m_rv;
    logic [35:0] m_rd  [4];
    logic [3:0]  m_opc;

    logic [3:0]  b_req;
    logic [31:0] b_add [4];
    logic [3:0]  b_wen;
    logic [3:0]  b_be  [4];
    logic [35:0] b_wd  [4];
    logic [35:0] b_rd  [4];
    logic [3:0]  b_rv;

    for (genvar g = 0; g < 4; g++) begin : g_m
        assign ms[g].req   = m_req[g];
        assign ms[g].add   = m_add[g];
        assign ms[g].wen   = m_wen[g];
        assign ms[g].be    = m_be[g];
        assign ms[g].wdata = m_wd[g];
        assign m_gnt[g]    = ms[g].gnt;
        assign m_rv[g]     = ms[g].r_valid;
        assign m_rd[g]     = ms[g].r_rdata;
        assign m_opc[g]    = ms[g].r_opc;
    end

    for (genvar g = 0; g < 4; g++) begin : g_b
        assign b_req[g]      = bk[g].req;
        assign b_add[g]      = bk[g].add;
        assign b_wen[g]      = bk[g].wen;
        assign b_be[g]       = bk[g].be;
        assign b_wd[g]       = bk[g].wdata;
        assign bk[g].gnt     = bk[g].req;
        assign bk[g].r_valid = b_rv[g];
        assign bk[g].r_rdata = b_rd[g];
        assign bk[g].r_opc   = 1'b0;

        // Bank returns {8+bank, address} one cycle after each grant
        always @(posedge clk_i) begin
            b_rv[g] <= bk[g].req;
            if (bk[g].req) begin
                b_rd[g] <= {4'(8 + g), bk[g].add};
            end
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [35:0] erd(input int b,
                                        input logic [31:0] a);
        return {4'(8 + b), a};
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        m_req = '0;
        m_wen = '1;
        for (int i = 0; i < 4; i++) begin
            m_add[i] = '0;
            m_be[i]  = '0;
            m_wd[i]  = '0;
        end
    endtask

    task automatic rd_req(input int i, input logic [31:0] a);
        m_req[i] = 1'b1;
        m_add[i] = a;
        m_wen[i] = 1'b1;
        m_be[i]  = 4'hF;
    endtask

    logic [3:0]  exp_g;
    logic [31:0] s_add [5];
    bit          rr;

    initial begin
`ifdef L2_INTL_RR_ARB_EN
        rr = 1'b1;
`else
        rr = 1'b0;
`endif
        for (int i = 0; i < 4; i++) b_rd[i] = '0;
        b_rv   = '0;
        rst_ni = 1'b0;
        idle();
        tick();
        tick();
        chk("rst_rv", 64'(m_rv), 64'h0);
        chk("rst_gnt", 64'(m_gnt), 64'h0);
        chk("rst_rd0", 64'(m_rd[0]), 64'h0);
        chk("rst_opc", 64'(m_opc), 64'h0);
        chk("idle_breq", 64'(b_req), 64'h0);
        chk("idle_add", 64'(b_add[0]), 64'h0);
        chk("idle_wen", 64'(b_wen), 64'hF);
        chk("idle_be", 64'(b_be[2]), 64'h0);
        rst_ni = 1'b1;
        tick();

        // single write from master 0 to bank 1
        m_req[0] = 1'b1;
        m_add[0] = 32'h1C00_0004;
        m_wen[0] = 1'b0;
        m_be[0]  = 4'hF;
        m_wd[0]  = 36'hA_DEAD_BEEF;
        #1;
        chk("w_breq", 64'(b_req), 64'h2);
        chk("w_gnt", 64'(m_gnt), 64'h1);
        chk("w_badd", 64'(b_add[1]), 64'h1C00_0004);
        chk("w_bwen", 64'(b_wen[1]), 64'h0);
        chk("w_bwd", 64'(b_wd[1]), 64'hA_DEAD_BEEF);
        tick();
        idle();
        chk("w_rv", 64'(m_rv), 64'h1);
        chk("w_rd", 64'(m_rd[0]), 64'(erd(1, 32'h1C00_0004)));
        chk("w_rd1", 64'(m_rd[1]), 64'h0);
        tick();
        chk("w_rv_off", 64'(m_rv), 64'h0);

        // masters 0 and 2 contend for bank 3
        for (int c = 0; c < 4; c++) begin
            rd_req(0, 32'h1C00_000C);
            rd_req(2, 32'h1C00_000C);
            exp_g = (rr && (c % 2 == 1)) ? 4'b0100 : 4'b0001;
            #1;
            chk("arb_gnt", 64'(m_gnt), 64'(exp_g));
            tick();
            chk("arb_rv", 64'(m_rv), 64'(exp_g));
            chk("arb_rd", 64'(m_rd[exp_g[2] ? 2 : 0]),
                64'(erd(3, 32'h1C00_000C)));
        end
        idle();
        tick();
        chk("arb_rv_off", 64'(m_rv), 64'h0);

        // four masters, four banks, one cycle
        rd_req(0, 32'h1C00_0108);
        rd_req(1, 32'h1C00_020C);
        rd_req(2, 32'h1C00_0300);
        rd_req(3, 32'h1C00_0404);
        #1;
        chk("par_gnt", 64'(m_gnt), 64'hF);
        chk("par_breq", 64'(b_req), 64'hF);
        tick();
        idle();
        chk("par_rv", 64'(m_rv), 64'hF);
        chk("par_rd0", 64'(m_rd[0]), 64'(erd(2, 32'h1C00_0108)));
        chk("par_rd1", 64'(m_rd[1]), 64'(erd(3, 32'h1C00_020C)));
        chk("par_rd2", 64'(m_rd[2]), 64'(erd(0, 32'h1C00_0300)));
        chk("par_rd3", 64'(m_rd[3]), 64'(erd(1, 32'h1C00_0404)));
        tick();

        // master 1 streams across banks 0,1,2,3,0
        s_add[0] = 32'h1C00_0010;
        s_add[1] = 32'h1C00_0014;
        s_add[2] = 32'h1C00_0018;
        s_add[3] = 32'h1C00_001C;
        s_add[4] = 32'h1C00_0020;
        for (int k = 0; k < 5; k++) begin
            rd_req(1, s_add[k]);
            #1;
            chk("str_gnt", 64'(m_gnt), 64'h2);
            tick();
            chk("str_rv", 64'(m_rv), 64'h2);
            chk("str_rd", 64'(m_rd[1]), 64'(erd(k % 4, s_add[k])));
        end
        idle();
        tick();
        chk("str_rv_off", 64'(m_rv), 64'h0);

        // reset right after a grant drops the pending response
        rd_req(3, 32'h1C00_0008);
        #1;
        chk("rst_g", 64'(m_gnt), 64'h8);
        tick();
        rst_ni = 1'b0;
        idle();
        #1;
        chk("mid_rv", 64'(m_rv), 64'h0);
        chk("mid_rd", 64'(m_rd[3]), 64'h0);
        tick();
        chk("mid_rv2", 64'(m_rv), 64'h0);
        rst_ni = 1'b1;
        tick();
        chk("post_rv", 64'(m_rv), 64'h0);
        tick();
        chk("post_rv2", 64'(m_rv), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
